// File: rtl/toggle_pulse_decoder.sv
// Converts a toggle-encoded event line into one-cycle pulses, with a wrapping
// event count and a bounded pending-event counter drained by valid/ready.
module toggle_pulse_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int PEND_MAX    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  input  logic             evt_ready,
  input  logic             clr_ovf,
  output logic             pulse,
  output logic [CNT_W-1:0] event_cnt,
  output logic             evt_valid,
  output logic [7:0]       pend_cnt,
  output logic             overflow,
  output logic             armed
);

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  localparam logic [7:0] PMAX = 8'(PEND_MAX);
  localparam logic [2:0] WTC  = 3'(SYNC_STAGES);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_tog_prev;
  logic [2:0]             r_wcnt;
  logic                   r_pulse;
  logic [CNT_W-1:0]       r_event_cnt;
  logic [7:0]             r_pend;
  logic                   r_ovf;

  logic w_tog_s;
  logic w_wdone;
  logic w_edge;
  logic w_dec;
  logic w_drop;

  assign w_tog_s = r_sync[SYNC_STAGES-1];
  assign w_wdone = (r_wcnt == WTC);
  // Edges are only honoured once the synchroniser has flushed its reset value.
  assign w_edge  = (r_state == ST_RUN) && (w_tog_s ^ r_tog_prev);
  assign w_dec   = evt_valid && evt_ready;
  assign w_drop  = w_edge && !w_dec && (r_pend == PMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= '0;
      r_tog_prev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], tog_in};
      r_tog_prev <= w_tog_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_WARMUP;
      r_wcnt  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_WARMUP && !w_wdone) begin
        r_wcnt <= r_wcnt + 3'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_WARMUP && w_wdone) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pulse     <= 1'b0;
      r_event_cnt <= '0;
    end else begin
      r_pulse <= w_edge;
      if (w_edge) begin
        r_event_cnt <= r_event_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // A simultaneous event and handshake cancel; a drop only happens when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 8'd0;
      r_ovf  <= 1'b0;
    end else begin
      case ({w_edge, w_dec})
        2'b10:   if (r_pend != PMAX) r_pend <= r_pend + 8'd1;
        2'b01:   r_pend <= r_pend - 8'd1;
        default: r_pend <= r_pend;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign pulse     = r_pulse;
  assign event_cnt = r_event_cnt;
  assign evt_valid = (r_pend != 8'd0);
  assign pend_cnt  = r_pend;
  assign overflow  = r_ovf;
  assign armed     = (r_state == ST_RUN);

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// Bench for toggle_pulse_decoder: directed scenarios plus random traffic,
// checked every cycle against a latency-based reference model.
module tb_toggle_pulse_decoder;

  localparam int S    = 2;
  localparam int CW   = 8;
  localparam int PMAX = 7;

  logic          clk;
  logic          rst;
  logic          tog_in;
  logic          evt_ready;
  logic          clr_ovf;
  logic          pulse;
  logic [CW-1:0] event_cnt;
  logic          evt_valid;
  logic [7:0]    pend_cnt;
  logic          overflow;
  logic          armed;

  int tests = 0;
  int fails = 0;

  // Reference model: tog_in sample history indexed by cycle since release.
  int hist[16];
  int c      = 0;
  int m_cnt  = 0;
  int m_pend = 0;
  int m_ovf  = 0;
  int m_pulse = 0;

  toggle_pulse_decoder #(.SYNC_STAGES(S), .CNT_W(CW), .PEND_MAX(PMAX)) dut (
    .clk(clk), .rst(rst), .tog_in(tog_in), .evt_ready(evt_ready),
    .clr_ovf(clr_ovf), .pulse(pulse), .event_cnt(event_cnt),
    .evt_valid(evt_valid), .pend_cnt(pend_cnt), .overflow(overflow),
    .armed(armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    int dec;
    int drop;
    @(posedge clk);
    if (rst) begin
      c = 0; m_cnt = 0; m_pend = 0; m_ovf = 0; m_pulse = 0;
    end else begin
      c++;
      hist[c % 16] = int'(tog_in);
      m_pulse = (c >= S + 2 && hist[(c - S) % 16] != hist[(c - S - 1) % 16]) ? 1 : 0;
      dec  = (m_pend != 0 && evt_ready) ? 1 : 0;
      drop = 0;
      if (m_pulse != 0) m_cnt = (m_cnt + 1) % (1 << CW);
      if (m_pulse != 0 && dec == 0) begin
        if (m_pend < PMAX) m_pend++;
        else drop = 1;
      end else if (m_pulse == 0 && dec != 0) begin
        m_pend--;
      end
      if (drop != 0) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
    #1;
    chk("pulse", pulse, m_pulse);
    chk("event_cnt", event_cnt, m_cnt);
    chk("pend_cnt", pend_cnt, m_pend);
    chk("evt_valid", evt_valid, (m_pend != 0) ? 1 : 0);
    chk("overflow", overflow, m_ovf);
    chk("armed", armed, (!rst && c >= S + 1) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic flip();
    tog_in = ~tog_in;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tog_in = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0;

    // Level held through reset is absorbed by warm-up.
    idle(2);
    rst = 1'b0;
    idle(2);
    chk("s1_armed_early", armed, 0);
    tick();
    chk("s1_armed", armed, 1);
    idle(20);
    chk("s1_cnt", event_cnt, 0);
    chk("s1_pend", pend_cnt, 0);

    // Single toggle: pulse after posedge k+2.
    flip();
    tick();
    tick();
    chk("s2_pulse_k1", pulse, 0);
    tick();
    chk("s2_pulse_k2", pulse, 1);
    tick();
    chk("s2_pulse_k3", pulse, 0);
    chk("s2_cnt", event_cnt, 1);
    chk("s2_pend", pend_cnt, 1);
    chk("s2_valid", evt_valid, 1);

    // Saturation and overflow.
    do_reset();
    idle(3);
    for (int i = 0; i < 9; i++) begin
      flip();
      idle(3);
    end
    idle(3);
    chk("s3_pend_sat", pend_cnt, 7);
    chk("s3_ovf", overflow, 1);
    chk("s3_cnt", event_cnt, 9);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("s3_ovf_clr", overflow, 0);
    chk("s3_pend_keep", pend_cnt, 7);

    // Back-to-back toggles with ready held high.
    evt_ready = 1'b1;
    idle(10);
    chk("s4_drained", pend_cnt, 0);
    flip();
    tick();
    flip();
    tick();
    tick();
    chk("s4_pulse_a", pulse, 1);
    chk("s4_pend_a", pend_cnt, 1);
    tick();
    chk("s4_pulse_b", pulse, 1);
    chk("s4_pend_b", pend_cnt, 1);
    tick();
    chk("s4_pulse_c", pulse, 0);
    chk("s4_pend_c", pend_cnt, 0);
    chk("s4_cnt", event_cnt, 11);

    // 256 events wrap the counter.
    do_reset();
    idle(3);
    for (int i = 0; i < 256; i++) begin
      flip();
      idle(2);
    end
    idle(4);
    chk("s5_cnt_wrap", event_cnt, 0);
    chk("s5_pend", pend_cnt, 0);
    chk("s5_ovf", overflow, 0);

    // Asynchronous reset with events pending.
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flip();
      idle(3);
    end
    idle(3);
    chk("s6_pend_pre", pend_cnt, 4);
    #3;
    rst = 1'b1;
    #1;
    chk("s6_pend_async", pend_cnt, 0);
    chk("s6_cnt_async", event_cnt, 0);
    chk("s6_valid_async", evt_valid, 0);
    chk("s6_armed_async", armed, 0);
    chk("s6_pulse_async", pulse, 0);
    tick();
    rst = 1'b0;
    idle(2);
    chk("s6_armed_early", armed, 0);
    tick();
    chk("s6_armed", armed, 1);
    idle(10);
    chk("s6_cnt_after", event_cnt, 0);

    // Random traffic: sparse draining, then mostly draining.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tog_in    = ($urandom_range(0, 2) == 0) ? ~tog_in : tog_in;
      evt_ready = ($urandom_range(0, 3) == 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      tick();
    end
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tog_in    = $urandom_range(0, 1) != 0;
      evt_ready = ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
